// File: rtl/ram_burst_port.sv
// ram_burst_port: splits one burst command into single-word req/gnt beats, read data through a skid FIFO
module ram_burst_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_we_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    output logic                    cmd_done_o,
    input  logic                    wdata_valid_i,
    output logic                    wdata_ready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rdata_valid_o,
    input  logic                    rdata_ready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q, cnt_q;
    logic                  we_q, inflight_q, done_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         fifo_cnt;
    logic                  accept, fire, last, credit_ok, push, pop;

    // a read beat may only be requested when its response is guaranteed a FIFO slot
    assign credit_ok = fifo_cnt + CW'(inflight_q) < CW'(FIFO_DEPTH);
    assign last      = cnt_q == len_q;
    assign accept    = cmd_valid_i & cmd_ready_o;
    assign fire      = mem_req_o & mem_gnt_i;
    // inflight_q is cleared by reset, so a response straddling a reset is dropped
    assign push      = mem_rvalid_i & inflight_q & ~we_q;
    assign pop       = rdata_valid_o & rdata_ready_i;

    assign cmd_ready_o   = state == IDLE;
    assign cmd_done_o    = done_q;
    assign mem_req_o     = state == WRITE ? wdata_valid_i : state == READ ? credit_ok : 1'b0;
    assign mem_we_o      = state == WRITE;
    assign mem_be_o      = '1;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_i;
    assign wdata_ready_o = (state == WRITE) & fire;
    assign rdata_valid_o = fifo_cnt != '0;
    assign rdata_o       = fifo_mem[rptr];

    // next-state: beats are issued until the last grant, then wait for its response
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (cmd_we_i ? WRITE : READ) : IDLE;
            WRITE,
            READ:    state_nx = fire && last ? DRAIN : state;
            DRAIN:   state_nx = mem_rvalid_i && inflight_q ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // burst registers: latch the command, advance address and beat count on each grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            inflight_q <= fire;
            done_q     <= (state == DRAIN) & mem_rvalid_i & inflight_q;
            if (accept) begin
                addr_q <= cmd_addr_i & ~ADDR_WIDTH'(BW - 1);
                len_q  <= cmd_len_i;
                we_q   <= cmd_we_i;
                cnt_q  <= '0;
            end else if (fire) begin
                addr_q <= addr_q + ADDR_WIDTH'(BW);
                cnt_q  <= cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // read skid FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            wptr     <= push ? wptr + PW'(1) : wptr;
            rptr     <= pop ? rptr + PW'(1) : rptr;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // read skid FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= mem_rdata_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));

    a_done_in_drain: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid_i && inflight_q && state == IDLE));
endmodule

// File: tb/tb_ram_burst_port.sv
// tb_ram_burst_port: randomized burst traffic against a queue-based model of the port
module tb_ram_burst_port;
    localparam int DEPTH = 4;

    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_we = 0, cmd_done;
    logic [31:0] cmd_addr = 0;
    logic [7:0]  cmd_len = 0;
    logic        wdata_valid = 0, wdata_ready, rdata_valid, rdata_ready = 0;
    logic [31:0] wdata = 0, rdata;
    logic        mem_req, mem_gnt = 0, mem_rvalid = 0, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [3:0]  mem_be;

    int          checks = 0, failures = 0;
    logic [31:0] exp_rd[$];
    logic [31:0] seen_addr[$];
    logic [31:0] wq[$];
    int          stall_from = -1, stall_cycles = 0, rdy_hold = 0;
    int          first_fire = 0, last_fire = 0, max_occ = 0;

    ram_burst_port dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
        .cmd_we_i(cmd_we), .cmd_len_i(cmd_len), .cmd_done_o(cmd_done),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_done"}, cmd_done, 0);
        chk({tag, "_wready"}, wdata_ready, 0);
        chk({tag, "_rvalid"}, rdata_valid, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_be"}, mem_be, 4'hF);
    endtask

    // one command from issue until its done pulse and every read beat delivered
    task automatic burst(input logic [31:0] addr, input int len, input bit we,
                         input int gpct, input int rpct);
        logic [31:0] base, fa, fa_nx;
        int beat, resp, widx, n;
        bit fired, done_seen, exp_done, wv, exp_req, fire;
        base = addr & ~32'h3;
        beat = 0; resp = 0; widx = 0; n = 0;
        fired = 0; done_seen = 0; exp_done = 0; wv = 0; fa = 0; fa_nx = 0;
        if (we && wq.size() == 0) for (int i = 0; i <= len; i++) wq.push_back($urandom);
        @(negedge clk);
        cmd_valid = 1; cmd_addr = addr; cmd_len = 8'(len); cmd_we = we;
        mem_gnt = 0; mem_rvalid = 0; wdata_valid = 0; rdata_ready = 0;
        #1;
        chk("accept_ready", cmd_ready, 1);
        chk("accept_req", mem_req, 0);
        @(negedge clk);
        cmd_valid = 0;
        while (!(done_seen && exp_rd.size() == 0) && n < 2000) begin
            mem_rvalid = fired;
            mem_rdata = (fired && !we) ? memf(fa) : $urandom;
            if (fired) resp++;
            mem_gnt = $urandom_range(99) < gpct;
            if (stall_from == beat && stall_cycles > 0) begin
                mem_gnt = 0;
                stall_cycles--;
            end
            rdata_ready = (n >= rdy_hold) && ($urandom_range(99) < rpct);
            if (we && !wv && widx <= len) wv = $urandom_range(99) < rpct;
            wdata_valid = wv;
            wdata = (widx <= len) ? wq[widx] : $urandom;
            #1;
            chk("done", cmd_done, exp_done);
            if (cmd_done) done_seen = 1;
            chk("cmd_ready", cmd_ready, done_seen);
            chk("rdata_valid", rdata_valid, exp_rd.size() != 0);
            exp_req = beat <= len && (we ? wv : (exp_rd.size() + int'(fired)) < DEPTH);
            chk("req", mem_req, exp_req);
            if (beat <= len) begin
                chk("addr", mem_addr, base + 32'(4 * beat));
                chk("we", mem_we, we);
                chk("be", mem_be, 4'hF);
            end
            fire = exp_req && mem_gnt;
            chk("wdata_ready", wdata_ready, we && fire);
            if (mem_req && mem_gnt) seen_addr.push_back(mem_addr);
            if (rdata_valid && rdata_ready && exp_rd.size() != 0) begin
                chk("rdata", rdata, exp_rd[0]);
                void'(exp_rd.pop_front());
            end
            if (fired && !we) exp_rd.push_back(memf(fa));
            if (exp_rd.size() > max_occ) max_occ = exp_rd.size();
            if (fire) begin
                if (beat == 0) first_fire = n;
                last_fire = n;
                if (we) begin
                    chk("wdata", mem_wdata, wq[widx]);
                    widx++;
                    wv = 0;
                end
                fa_nx = base + 32'(4 * beat);
                beat++;
            end
            exp_done = fired && resp == len + 1;
            fired = fire;
            fa = fa_nx;
            @(negedge clk);
            n++;
        end
        chk("burst_timeout", n < 2000, 1);
        wq.delete();
        exp_rd.delete();
        rdy_hold = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_idle("reset");
        rst = 0;

        // consecutive read beats with free-flowing grant and ready
        seen_addr.delete();
        burst(32'h100, 3, 0, 100, 100);
        chk("t1_beats", seen_addr.size(), 4);
        chk("t1_a3", seen_addr.size() == 4 ? seen_addr[3] : 0, 32'h10C);
        chk("t1_back_to_back", last_fire - first_fire, 3);

        // unaligned write start
        seen_addr.delete();
        wq.push_back(32'hA5A5A5A5);
        wq.push_back(32'h5A5A5A5A);
        burst(32'h203, 1, 1, 100, 100);
        chk("t2_a0", seen_addr.size() == 2 ? seen_addr[0] : 0, 32'h200);
        chk("t2_a1", seen_addr.size() == 2 ? seen_addr[1] : 0, 32'h204);

        // grant withheld for 5 cycles mid-burst
        seen_addr.delete();
        stall_from = 2; stall_cycles = 5;
        burst(32'h3000, 5, 0, 100, 100);
        chk("t3_beats", seen_addr.size(), 6);
        chk("t3_stall_used", stall_cycles, 0);
        stall_from = -1;

        // downstream stalled: credit limits outstanding reads to the FIFO depth
        seen_addr.delete();
        max_occ = 0; rdy_hold = 30;
        burst(32'h4000, 7, 0, 100, 100);
        chk("t4_beats", seen_addr.size(), 8);
        chk("t4_max_occ", max_occ, DEPTH);

        // address wrap at the top of the space
        seen_addr.delete();
        burst(32'hFFFFFFFC, 1, 0, 100, 100);
        chk("t5_a0", seen_addr.size() == 2 ? seen_addr[0] : 1, 32'hFFFFFFFC);
        chk("t5_a1", seen_addr.size() == 2 ? seen_addr[1] : 1, 32'h0);

        // reset after two read grants, with a response arriving right after reset
        @(negedge clk);
        cmd_valid = 1; cmd_addr = 32'h400; cmd_len = 7; cmd_we = 0;
        mem_gnt = 1; rdata_ready = 0; mem_rvalid = 0;
        @(negedge clk);
        cmd_valid = 0;
        #1 chk("t6_req0", mem_req, 1);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h1111;
        #1 chk("t6_req1", mem_req, 1);
        @(negedge clk);
        rst = 1; mem_gnt = 0; mem_rdata = 32'h2222;
        @(negedge clk);
        rst = 0; mem_rdata = 32'h3333;
        #1 check_idle("t6_after_rst");
        @(negedge clk);
        mem_rvalid = 0;
        #1 chk("t6_fifo_empty", rdata_valid, 0);
        chk("t6_done_quiet", cmd_done, 0);
        burst(32'h500, 2, 0, 100, 100);

        // randomized mix of reads and writes
        for (int k = 0; k < 14; k++)
            burst($urandom, $urandom_range(9), 1'($urandom_range(1)),
                  $urandom_range(30, 100), $urandom_range(30, 100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
